// File: rtl/tlul_chk_pkg.sv
// Error codes of the TL-UL protocol checker and the helper that ranks simultaneous violations.
package tlul_chk_pkg;

    typedef enum logic [2:0] {
        ErrNone     = 3'd0,
        ErrAStable  = 3'd1,
        ErrDStable  = 3'd2,
        ErrSrcBusy  = 3'd3,
        ErrNoReq    = 3'd4,
        ErrOpc      = 3'd5,
        ErrOverflow = 3'd6
    } err_e;

    // Lowest code wins when several violations hit in the same cycle.
    function automatic err_e pick_err(logic [6:1] hits);
        err_e code;
        code = ErrNone;
        for (int i = 6; i >= 1; i--) begin
            if (hits[i]) code = err_e'(3'(i));
        end
        return code;
    endfunction

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TileLink-UL channel definitions shared by the bus checker and its users.
package tlul_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_SZW = 2;
    localparam int TL_DBW = TL_DW / 8;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_chk_port.sv
// Single-port TL-UL monitor: pending-source table, channel stability history,
// outstanding/request counters and sticky first-error capture.
module tlul_chk_port
    import tlul_pkg::*;
    import tlul_chk_pkg::*;
#(
    parameter int SrcW   = 3,
    parameter int MaxOut = 4,
    parameter int CntW   = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  tl_h2d_t                      h2d,
    input  tl_d2h_t                      d2h,
    input  logic                         en_i,
    input  logic                         clear_i,
    output logic                         err_o,
    output logic                         err_next_o,
    output err_e                         err_code_o,
    output logic [$clog2(MaxOut+1)-1:0]  outstanding_o,
    output logic [CntW-1:0]              req_cnt_o
);

    localparam int Entries = 2 ** SrcW;
    localparam int OutW    = $clog2(MaxOut + 1);
    localparam logic [OutW-1:0] MaxOutV = OutW'(MaxOut);

    typedef struct packed {
        tl_a_op_e          op;
        logic [TL_SZW-1:0] size;
        logic [TL_AIW-1:0] source;
        logic [TL_AW-1:0]  address;
        logic [TL_DBW-1:0] mask;
        logic [TL_DW-1:0]  data;
    } a_hist_t;

    typedef struct packed {
        tl_d_op_e          op;
        logic [TL_SZW-1:0] size;
        logic [TL_AIW-1:0] source;
        logic              error;
        logic [TL_DW-1:0]  data;
    } d_hist_t;

    logic [Entries-1:0] valid_q, valid_d, is_get_q, is_get_d, valid_ret;
    logic               a_wait_q, a_wait_d, d_wait_q, d_wait_d;
    a_hist_t            a_hist_q, a_hist_d, a_now;
    d_hist_t            d_hist_q, d_hist_d, d_now;
    logic [OutW-1:0]    out_q, out_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               err_q, err_d;
    err_e               code_q, code_d, code_now;

    logic               a_acc, d_acc, retire, full, allocate;
    logic [SrcW-1:0]    a_idx, d_idx;
    logic [6:1]         hits;
    tl_d_op_e           want_op;

    assign a_now = '{op: h2d.a_opcode, size: h2d.a_size, source: h2d.a_source,
                     address: h2d.a_address, mask: h2d.a_mask, data: h2d.a_data};
    assign d_now = '{op: d2h.d_opcode, size: d2h.d_size, source: d2h.d_source,
                     error: d2h.d_error, data: d2h.d_data};

    assign a_acc  = h2d.a_valid & d2h.a_ready;
    assign d_acc  = d2h.d_valid & h2d.d_ready;
    assign a_idx  = h2d.a_source[SrcW-1:0];
    assign d_idx  = d2h.d_source[SrcW-1:0];
    assign retire = d_acc & valid_q[d_idx];
    assign full   = (out_q == MaxOutV) & ~retire;

    // The response retires first so a same-cycle request may reuse its source.
    always_comb begin
        valid_ret = valid_q;
        if (retire) valid_ret[d_idx] = 1'b0;
    end

    // An overflowing or colliding request is flagged but never enters the table,
    // which keeps the outstanding count equal to the number of live entries.
    assign allocate = a_acc & ~valid_ret[a_idx] & ~full;
    assign want_op  = is_get_q[d_idx] ? AccessAckData : AccessAck;

    always_comb begin
        hits[1] = a_wait_q & (~h2d.a_valid | (a_now != a_hist_q));
        hits[2] = d_wait_q & (~d2h.d_valid | (d_now != d_hist_q));
        hits[3] = a_acc & valid_ret[a_idx];
        hits[4] = d_acc & ~valid_q[d_idx];
        hits[5] = retire & (d2h.d_opcode != want_op);
        hits[6] = a_acc & full;
    end

    assign code_now = pick_err(hits);

    always_comb begin
        valid_d  = valid_ret;
        is_get_d = is_get_q;
        if (allocate) begin
            valid_d[a_idx]  = 1'b1;
            is_get_d[a_idx] = (h2d.a_opcode == Get);
        end

        unique case ({allocate, retire})
            2'b10:   out_d = out_q + 1'b1;
            2'b01:   out_d = out_q - 1'b1;
            default: out_d = out_q;
        endcase

        cnt_d    = (a_acc && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
        a_wait_d = h2d.a_valid & ~d2h.a_ready;
        d_wait_d = d2h.d_valid & ~h2d.d_ready;
        a_hist_d = a_now;
        d_hist_d = d_now;

        err_d  = err_q;
        code_d = code_q;
        if (clear_i) begin
            err_d  = 1'b0;
            code_d = ErrNone;
        end else if (en_i && !err_q && (code_now != ErrNone)) begin
            err_d  = 1'b1;
            code_d = code_now;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q  <= '0;
            is_get_q <= '0;
            a_wait_q <= 1'b0;
            d_wait_q <= 1'b0;
            a_hist_q <= '0;
            d_hist_q <= '0;
            out_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            code_q   <= ErrNone;
        end else begin
            valid_q  <= valid_d;
            is_get_q <= is_get_d;
            a_wait_q <= a_wait_d;
            d_wait_q <= d_wait_d;
            a_hist_q <= a_hist_d;
            d_hist_q <= d_hist_d;
            out_q    <= out_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    assign err_o         = err_q;
    assign err_next_o    = err_d;
    assign err_code_o    = code_q;
    assign outstanding_o = out_q;
    assign req_cnt_o     = cnt_q;

endmodule

// File: rtl/tlul_checker_multi.sv
// N-port TL-UL protocol checker: per-port monitors plus the interrupt reduction
// and the registered record of which port failed first.
module tlul_checker_multi
    import tlul_pkg::*;
    import tlul_chk_pkg::*;
#(
    parameter int N      = 2,
    parameter int SrcW   = 3,
    parameter int MaxOut = 4,
    parameter int CntW   = 16
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  tl_h2d_t [N-1:0]                        h2d,
    input  tl_d2h_t [N-1:0]                        d2h,
    input  logic [N-1:0]                           en_i,
    input  logic                                   clear_i,
    output logic [N-1:0]                           err_o,
    output err_e [N-1:0]                           err_code_o,
    output logic                                   err_any_o,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]   first_port_o,
    output logic [N-1:0][$clog2(MaxOut+1)-1:0]     outstanding_o,
    output logic [N-1:0][CntW-1:0]                 req_cnt_o
);

    localparam int FpW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   err_next;
    logic           any_q, any_d;
    logic [FpW-1:0] first_q, first_d, first_hit;

    for (genvar gi = 0; gi < N; gi++) begin : g_port
        tlul_chk_port #(
            .SrcW   (SrcW),
            .MaxOut (MaxOut),
            .CntW   (CntW)
        ) u_port (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .h2d           (h2d[gi]),
            .d2h           (d2h[gi]),
            .en_i          (en_i[gi]),
            .clear_i       (clear_i),
            .err_o         (err_o[gi]),
            .err_next_o    (err_next[gi]),
            .err_code_o    (err_code_o[gi]),
            .outstanding_o (outstanding_o[gi]),
            .req_cnt_o     (req_cnt_o[gi])
        );
    end

    // Looking at next-state flags lets first_port_o land in the same cycle as err_o.
    always_comb begin
        first_hit = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (err_next[i]) first_hit = FpW'(i);
        end
        any_d   = |err_next;
        first_d = first_q;
        if (clear_i) begin
            first_d = '0;
        end else if (!any_q && any_d) begin
            first_d = first_hit;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            any_q   <= 1'b0;
            first_q <= '0;
        end else begin
            any_q   <= any_d;
            first_q <= first_d;
        end
    end

    assign err_any_o    = any_q;
    assign first_port_o = first_q;

endmodule

// File: doc/tlul_checker_multi.md
# tlul_checker_multi

Synthesizable, run-time protocol checker for N TL-UL ports, intended for bus-fabric debug and silicon bring-up. Per port it tracks outstanding transactions by source ID, checks A/D channel stability and request/response pairing, and latches the first violation into sticky status registers. Its status outputs drive the debug CSR block and an interrupt line. It monitors only and never drives the bus.

## Interface
Parameters:
- `N`, 2: number of monitored ports, 1..32.
- `SrcW`, 3: low source bits tracked; the table has 2**SrcW entries, and `SrcW` must not exceed `tlul_pkg::TL_AIW`.
- `MaxOut`, 4: maximum outstanding transactions allowed per port, 1..2**SrcW.
- `CntW`, 16: width of the saturating accepted-request counter.

Ports:
- `clk_i` input, 1: clock.
- `rst_ni` input, 1: reset, asynchronous, active-low.
- `h2d` input, `tlul_pkg::tl_h2d_t [N]`: host-to-device channel of each port.
- `d2h` input, `tlul_pkg::tl_d2h_t [N]`: device-to-host channel of each port.
- `en_i` input, N: per-port check enable.
- `clear_i` input, 1: clears all sticky error state (pulse).
- `err_o` output, N: sticky per-port error flag.
- `err_code_o` output, `tlul_chk_pkg::err_e [N]`: code of the first error on each port.
- `err_any_o` output, 1: OR of `err_o` (interrupt).
- `first_port_o` output, `$clog2(N)` (min 1): index of the first port to fail.
- `outstanding_o` output, `[N][$clog2(MaxOut+1)]`: current outstanding count per port.
- `req_cnt_o` output, `[N][CntW]`: saturating count of accepted requests per port.

## Operation
- A request is accepted when `a_valid & a_ready`. A response is accepted when `d_valid & d_ready`. The index used is `source[SrcW-1:0]`.
- Each port has a pending table with one entry per index: a valid bit plus an `is_get` bit (set when `a_opcode == Get`).
- Checks per port, active only when `en_i[p]`. Codes in `err_e`, in priority order (lowest value wins):
  - 1 `ErrAStable`: in the previous cycle a request was valid and not accepted, and this cycle `a_valid` dropped or one of opcode/size/source/address/mask/data changed.
  - 2 `ErrDStable`: the same rule on the D channel (opcode/size/source/error/data).
  - 3 `ErrSrcBusy`: a request is accepted while its source entry is still valid after same-cycle retirement.
  - 4 `ErrNoReq`: a response is accepted for a source entry that was not valid at the start of the cycle.
  - 5 `ErrOpc`: the response opcode mismatches the entry. AccessAckData is required iff `is_get`.
  - 6 `ErrOverflow`: a request is accepted while outstanding == `MaxOut` and no response retires in the same cycle.
- Same cycle, same source: the response is processed first (retire), then the request (allocate). A same-cycle response to a request that was not previously outstanding is code 4.
- Bus tracking continues while `en_i[p]` is low (table, counters, stability history). Only error capture is gated.
- First error on a port: set `err_o[p]` and load `err_code_o[p]`. Later errors are ignored until `clear_i`.
- `first_port_o` is loaded when `err_any_o` goes from 0 to 1. If several ports fail in the same cycle, the lowest index is loaded.
- `clear_i` zeroes `err_o`, `err_code_o` and `first_port_o`. It does not touch the tables or counters. If `clear_i` coincides with a new error, the clear has priority and the error is lost.
- `req_cnt_o` increments on each accepted request and saturates at all-ones. `outstanding_o` is +1 on allocate and −1 on retire; simultaneous allocate and retire leaves it unchanged.

## Timing
- All outputs are registered. An error is visible on `err_o`/`err_code_o` 1 cycle after the offending clock edge. `err_any_o` and `first_port_o` are valid in the same cycle as `err_o`.
- `outstanding_o` and `req_cnt_o` update 1 cycle after the handshake.
- Reset: every output, table bit, counter and stability history register is 0. Reset applied mid-transaction discards all pending state, so a response arriving after reset is code 4.
- There are no combinational paths from inputs to outputs.

## Structure
- Package `tlul_chk_pkg`: the `err_e` enum (`logic [2:0]`; 0 `ErrNone` … 6 `ErrOverflow`).
- Sub-module `tlul_chk_port`, one instance per port. It holds the pending table, stability history, counters and first-error logic.
- The top level holds the generate loop, the `first_port_o` priority encoder and the `err_any_o` reduction.

## Test plan
- Get on source 2, AccessAckData 3 cycles later → outstanding_o 1 then 0; req_cnt 1; err_o = 0.
- a_valid held while a_ready = 0, address changes 0x10→0x14 → err_o[p] = 1, code 1, one cycle after the change.
- AccessAck on source 5 with no request → code 4. A following Get on source 6 with a mismatched AccessAck → err_code_o stays 4 (sticky).
- MaxOut = 4: five Gets on sources 0–4 with no responses → code 6 on the fifth. Repeat with a response retiring in the same cycle → no error.
- Ports 3 and 1 fail in the same cycle → first_port_o = 1. Then `clear_i` → err_o = 0, first_port_o = 0, counters kept.
- Same-source response and new request in the same cycle → no error, outstanding unchanged. Assert `rst_ni` mid-flight → all outputs 0, the late response gives code 4.
